// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment (PLL + reset logic).
// RELOCK_REQ is a one-cycle pulse with no ready; every other signal is a level, so no valid/ready pair exists.
interface pll_lock_supervisor_if;
  logic       PLL_LOCK;
  logic       RELOCK_REQ;
  logic       PLL_POWERDOWN_N;
  logic       CLK_READY;
  logic       FAIL;
  logic [2:0] STATE;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  modport master (
    output PLL_LOCK, RELOCK_REQ,
    input  PLL_POWERDOWN_N, CLK_READY, FAIL, STATE, RETRY_CNT, LOSS_CNT
  );

  modport slave (
    input  PLL_LOCK, RELOCK_REQ,
    output PLL_POWERDOWN_N, CLK_READY, FAIL, STATE, RETRY_CNT, LOSS_CNT
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Powers the fabric PLL up, waits for a stable lock with bounded retries, and publishes CLK_READY.
// Runs on the free-running reference clock so it keeps working while the PLL is down.
module pll_lock_supervisor #(
  parameter int PD_CYCLES           = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input logic                  CLK,
  input logic                  RST,
  pll_lock_supervisor_if.slave pll
);

  localparam int MAX_AB = (PD_CYCLES > LOCK_TIMEOUT_CYCLES) ? PD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_T  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int TW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] PD_LAST     = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT   = {TW{1'b1}};
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_POWERDOWN = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [3:0]    retry_q, retry_d, retry_inc;
  logic [7:0]    loss_q, loss_d;
  logic          lock_meta, lock_s;
  logic          restart;
  logic          pdn_q, ready_q, fail_q;

  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    restart = 1'b0;
    if (pll.RELOCK_REQ) begin
      // Also restarts the power-down timer when already in POWERDOWN.
      state_d = S_POWERDOWN;
      retry_d = 4'd0;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_POWERDOWN: if (timer_q == PD_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABILIZE;
          end else if (timer_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? S_FAILED : S_POWERDOWN;
          end
        end
        S_STABILIZE: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = 4'd0;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_POWERDOWN;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        S_FAILED: state_d = S_FAILED;
        default:  state_d = S_POWERDOWN;
      endcase
    end
    if (state_d != state_q) restart = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state_q   <= S_POWERDOWN;
      timer_q   <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
      pdn_q     <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      lock_meta <= pll.PLL_LOCK;
      lock_s    <= lock_meta;
      state_q   <= state_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      // Saturate so long stays in RUN/FAILED never wrap back into a timeout match.
      if (restart)                timer_q <= '0;
      else if (timer_q != TIMER_SAT) timer_q <= timer_q + 1'b1;
      // Moore decodes taken from the next state so they move on the same edge as STATE.
      pdn_q   <= !((state_d == S_POWERDOWN) || (state_d == S_FAILED));
      ready_q <= (state_d == S_RUN);
      fail_q  <= (state_d == S_FAILED);
    end
  end

  assign pll.PLL_POWERDOWN_N = pdn_q;
  assign pll.CLK_READY       = ready_q;
  assign pll.FAIL            = fail_q;
  assign pll.STATE           = state_q;
  assign pll.RETRY_CNT       = retry_q;
  assign pll.LOSS_CNT        = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/relock/reset traffic,
// each cycle's expected outputs queued by a reference model and compared by a monitor.
module tb_pll_lock_supervisor;

  localparam int PD  = 4;
  localparam int TO  = 32;
  localparam int STB = 8;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic rst;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PD_CYCLES(PD), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(STB), .MAX_RETRIES(MR)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .pll(bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_state, m_t, m_retry, m_loss;
  bit m_l1, m_ls;

  task automatic model_step(input logic r, input logic l, input logic q);
    int  ns;
    bit  rs;
    if (r) begin
      m_state = 0; m_t = 0; m_retry = 0; m_loss = 0; m_l1 = 0; m_ls = 0;
      return;
    end
    ns = m_state;
    rs = 0;
    if (q) begin
      ns = 0; m_retry = 0; rs = 1;
    end else begin
      case (m_state)
        0: if (m_t + 1 == PD) ns = 1;
        1: begin
          if (m_ls) ns = 2;
          else if (m_t + 1 == TO) begin
            m_retry = m_retry + 1;
            ns = (m_retry == MR) ? 4 : 0;
          end
        end
        2: begin
          if (!m_ls) ns = 1;
          else if (m_t + 1 == STB) begin ns = 3; m_retry = 0; end
        end
        3: if (!m_ls) begin ns = 0; if (m_loss < 255) m_loss = m_loss + 1; end
        default: ;
      endcase
    end
    m_t = (rs || ns != m_state) ? 0 : m_t + 1;
    m_state = ns;
    m_ls = m_l1;
    m_l1 = l;
  endtask

  function automatic logic [17:0] model_vec();
    return {3'(m_state), (m_state != 0 && m_state != 4), (m_state == 3), (m_state == 4),
            4'(m_retry), 8'(m_loss)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) begin
    logic [17:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.STATE, bus.PLL_POWERDOWN_N, bus.CLK_READY, bus.FAIL, bus.RETRY_CNT, bus.LOSS_CNT};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t got st=%0d pdn=%0b rdy=%0b fail=%0b retry=%0d loss=%0d exp st=%0d pdn=%0b rdy=%0b fail=%0b retry=%0d loss=%0d",
                 $time, a[17:15], a[14], a[13], a[12], a[11:8], a[7:0],
                 e[17:15], e[14], e[13], e[12], e[11:8], e[7:0]);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic l, input logic q);
    rst            = r;
    bus.PLL_LOCK   = l;
    bus.RELOCK_REQ = q;
    model_step(r, l, q);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #2;
  endtask

  int n;
  logic lk;

  initial begin
    rst = 1'b1;
    bus.PLL_LOCK = 1'b0;
    bus.RELOCK_REQ = 1'b0;

    repeat (3) cycle(1, 0, 0);
    check("reset_state", int'(bus.STATE), 0);
    check("reset_pdn", int'(bus.PLL_POWERDOWN_N), 0);
    check("reset_loss", int'(bus.LOSS_CNT), 0);

    // Normal start
    repeat (3) cycle(0, 0, 0);
    check("pd_hold", int'(bus.PLL_POWERDOWN_N), 0);
    cycle(0, 0, 0);
    check("pd_release", int'(bus.PLL_POWERDOWN_N), 1);
    repeat (10) cycle(0, 0, 0);
    n = 0;
    do begin cycle(0, 1, 0); n++; end while (bus.CLK_READY !== 1'b1 && n < 40);
    check("ready_rise_latency", n, STB + 3);
    check("start_retry", int'(bus.RETRY_CNT), 0);

    // Glitch during STABILIZE, with one timeout already on the retry counter
    cycle(0, 0, 1);
    repeat (PD + TO + PD) cycle(0, 0, 0);
    check("timeout_retry", int'(bus.RETRY_CNT), 1);
    repeat (5) cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check("glitch_back_to_wait", int'(bus.STATE), 1);
    check("glitch_retry_kept", int'(bus.RETRY_CNT), 1);
    n = 2;
    do begin cycle(0, 1, 0); n++; end while (bus.CLK_READY !== 1'b1 && n < 40);
    check("glitch_ready_latency", n, STB + 3);
    check("run_retry_clear", int'(bus.RETRY_CNT), 0);

    // Lock never asserts
    cycle(1, 0, 0);
    repeat (MR * (PD + TO)) cycle(0, 0, 0);
    check("failed_state", int'(bus.STATE), 4);
    check("failed_flag", int'(bus.FAIL), 1);
    check("failed_pdn", int'(bus.PLL_POWERDOWN_N), 0);
    check("failed_retry", int'(bus.RETRY_CNT), MR);
    repeat (50) cycle(0, 1, 0);
    check("failed_hold", int'(bus.STATE), 4);

    // RELOCK_REQ from FAILED
    cycle(0, 0, 1);
    check("relock_failed_state", int'(bus.STATE), 0);
    check("relock_failed_retry", int'(bus.RETRY_CNT), 0);

    // Lock losses in RUN
    cycle(1, 1, 0);
    repeat (20) cycle(0, 1, 0);
    check("bringup_ready", int'(bus.CLK_READY), 1);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin cycle(0, 0, 0); n++; end while (bus.CLK_READY !== 1'b0 && n < 10);
      check("loss_fall_latency", n, 3);
      check("loss_pdn_low", int'(bus.PLL_POWERDOWN_N), 0);
      repeat (20) cycle(0, 1, 0);
    end
    check("loss_cnt_3", int'(bus.LOSS_CNT), 3);

    // RELOCK_REQ from RUN, then coincident with a lock loss
    cycle(0, 1, 1);
    check("relock_run_ready", int'(bus.CLK_READY), 0);
    check("relock_run_loss", int'(bus.LOSS_CNT), 3);
    repeat (20) cycle(0, 1, 0);
    check("relock_run_back", int'(bus.CLK_READY), 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    check("relock_on_loss_cnt", int'(bus.LOSS_CNT), 3);
    check("relock_on_loss_state", int'(bus.STATE), 0);
    repeat (20) cycle(0, 1, 0);

    // Saturation: 297 more losses make 300
    for (int i = 0; i < 297; i++) begin
      repeat ($urandom_range(1, 4)) cycle(0, 0, 0);
      repeat ($urandom_range(20, 30)) cycle(0, 1, 0);
    end
    check("loss_cnt_sat", int'(bus.LOSS_CNT), 255);

    // Mid-operation reset in STABILIZE and in RUN
    cycle(1, 1, 0);
    repeat (8) cycle(0, 1, 0);
    check("pre_reset_stabilize", int'(bus.STATE), 2);
    cycle(1, 1, 0);
    check("rst_stab_state", int'(bus.STATE), 0);
    check("rst_stab_pdn", int'(bus.PLL_POWERDOWN_N), 0);
    repeat (20) cycle(0, 1, 0);
    check("rst_stab_recover", int'(bus.CLK_READY), 1);
    cycle(1, 1, 0);
    check("rst_run_ready", int'(bus.CLK_READY), 0);
    check("rst_run_state", int'(bus.STATE), 0);
    repeat (20) cycle(0, 1, 0);
    check("rst_run_recover", int'(bus.CLK_READY), 1);

    // Random traffic
    lk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      cycle(($urandom_range(0, 599) == 0), lk, ($urandom_range(0, 149) == 0));
    end

    cycle(0, lk, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
